race_screen_sequencer: RTL and testbench

Top-level game flow controller; owns the 2-bit current_screen that drives the domain unit's player buttons, menu manager and end-game logic.
- Leaves MENU when the menu countdown completes.
- Watches the four player positions during GAME and declares a winner by fixed priority.
- Aborts an abandoned race on inactivity timeout.
- Returns to MENU on the end-game reset_all pulse.

---
 rtl/race_screen_sequencer.sv | 143 ++++++++++++++
 tb/tb_race_screen_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/race_screen_sequencer.sv
// Game flow controller: MENU -> GAME -> END screens, finish-line winner
// arbitration (red > blue > green > yellow) and idle-timeout race abort.
module race_screen_sequencer #(
    parameter int unsigned MAX_POS                = 16,
    parameter int unsigned IDLE_TIMEOUT_CLK_COUNT = 1500000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       is_in_menu,
    input  logic                       reset_all,
    input  logic                       red_ready_to_play,
    input  logic                       blue_ready_to_play,
    input  logic                       green_ready_to_play,
    input  logic                       yellow_ready_to_play,
    input  logic [$clog2(MAX_POS)-1:0] red_cur_pos,
    input  logic [$clog2(MAX_POS)-1:0] blue_cur_pos,
    input  logic [$clog2(MAX_POS)-1:0] green_cur_pos,
    input  logic [$clog2(MAX_POS)-1:0] yellow_cur_pos,
    input  logic                       red_activity,
    input  logic                       blue_activity,
    input  logic                       green_activity,
    input  logic                       yellow_activity,
    output logic [1:0]                 current_screen,
    output logic [3:0]                 winner,
    output logic                       winner_valid,
    output logic                       race_timeout,
    output logic                       game_over
);

    localparam int unsigned PW = $clog2(MAX_POS);
    localparam int unsigned CW = (IDLE_TIMEOUT_CLK_COUNT == 0) ? 1
                                 : $clog2(IDLE_TIMEOUT_CLK_COUNT + 1);
    localparam bit             TIMEOUT_EN = (IDLE_TIMEOUT_CLK_COUNT != 0);
    localparam logic [PW-1:0]  FIN_POS    = PW'(MAX_POS - 1);
    localparam logic [CW-1:0]  IDLE_LAST  = CW'(IDLE_TIMEOUT_CLK_COUNT - 1);

    localparam logic [1:0] S_MENU = 2'd0;
    localparam logic [1:0] S_GAME = 2'd1;
    localparam logic [1:0] S_END  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [3:0]    winner_q, winner_d;
    logic          winner_valid_q, winner_valid_d;
    logic          race_timeout_q, race_timeout_d;
    logic          game_over_q, game_over_d;
    logic [CW-1:0] idle_q, idle_d;
    logic          is_in_menu_q;

    logic [3:0]    fin;
    logic          any_act;
    logic          start_evt;

    assign fin = {yellow_ready_to_play & (yellow_cur_pos == FIN_POS),
                  green_ready_to_play  & (green_cur_pos  == FIN_POS),
                  blue_ready_to_play   & (blue_cur_pos   == FIN_POS),
                  red_ready_to_play    & (red_cur_pos    == FIN_POS)};

    assign any_act   = red_activity | blue_activity | green_activity | yellow_activity;
    assign start_evt = is_in_menu_q & ~is_in_menu;

    always_comb begin
        state_d        = state_q;
        winner_d       = winner_q;
        winner_valid_d = winner_valid_q;
        race_timeout_d = race_timeout_q;
        idle_d         = idle_q;
        game_over_d    = 1'b0;

        if (reset_all) begin
            state_d        = S_MENU;
            winner_d       = '0;
            winner_valid_d = 1'b0;
            race_timeout_d = 1'b0;
            idle_d         = '0;
        end else begin
            case (state_q)
                S_MENU: begin
                    winner_d       = '0;
                    winner_valid_d = 1'b0;
                    race_timeout_d = 1'b0;
                    idle_d         = '0;
                    if (start_evt) state_d = S_GAME;
                end
                S_GAME: begin
                    if (|fin) begin
                        state_d        = S_END;
                        // Lowest set bit isolates the highest-priority finisher.
                        winner_d       = fin & (~fin + 4'd1);
                        winner_valid_d = 1'b1;
                        race_timeout_d = 1'b0;
                        game_over_d    = 1'b1;
                    end else if (TIMEOUT_EN && !any_act && idle_q == IDLE_LAST) begin
                        state_d        = S_END;
                        winner_d       = '0;
                        winner_valid_d = 1'b0;
                        race_timeout_d = 1'b1;
                        game_over_d    = 1'b1;
                    end else if (any_act) begin
                        idle_d = '0;
                    end else if (idle_q != '1) begin
                        idle_d = idle_q + CW'(1);
                    end
                end
                S_END: begin
                end
                default: begin
                    state_d        = S_MENU;
                    winner_d       = '0;
                    winner_valid_d = 1'b0;
                    race_timeout_d = 1'b0;
                    idle_d         = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= S_MENU;
            winner_q       <= '0;
            winner_valid_q <= 1'b0;
            race_timeout_q <= 1'b0;
            game_over_q    <= 1'b0;
            idle_q         <= '0;
            is_in_menu_q   <= 1'b1;
        end else begin
            state_q        <= state_d;
            winner_q       <= winner_d;
            winner_valid_q <= winner_valid_d;
            race_timeout_q <= race_timeout_d;
            game_over_q    <= game_over_d;
            idle_q         <= idle_d;
            is_in_menu_q   <= is_in_menu;
        end
    end

    assign current_screen = state_q;
    assign winner         = winner_q;
    assign winner_valid   = winner_valid_q;
    assign race_timeout   = race_timeout_q;
    assign game_over      = game_over_q;

endmodule

// File: tb/tb_race_screen_sequencer.sv
// Bench for race_screen_sequencer: directed scenarios plus randomized races,
// checked against a screen-level reference model.
module tb_race_screen_sequencer;

    localparam int unsigned MAX_POS = 16;
    localparam int unsigned IDLE_TO = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       is_in_menu;
    logic       reset_all;
    logic [3:0] ready;
    logic [3:0] pos [4];
    logic [3:0] act;

    logic [1:0] current_screen;
    logic [3:0] winner;
    logic       winner_valid;
    logic       race_timeout;
    logic       game_over;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state: what the outputs must show after the next edge.
    int unsigned m_screen;
    logic [3:0]  m_winner;
    bit          m_wv, m_to, m_go, m_menu_q;
    int unsigned m_idle;

    always #5 clk = ~clk;

    race_screen_sequencer #(
        .MAX_POS                (MAX_POS),
        .IDLE_TIMEOUT_CLK_COUNT (IDLE_TO)
    ) dut (
        .clk                  (clk),
        .reset                (rst_n),
        .is_in_menu           (is_in_menu),
        .reset_all            (reset_all),
        .red_ready_to_play    (ready[0]),
        .blue_ready_to_play   (ready[1]),
        .green_ready_to_play  (ready[2]),
        .yellow_ready_to_play (ready[3]),
        .red_cur_pos          (pos[0]),
        .blue_cur_pos         (pos[1]),
        .green_cur_pos        (pos[2]),
        .yellow_cur_pos       (pos[3]),
        .red_activity         (act[0]),
        .blue_activity        (act[1]),
        .green_activity       (act[2]),
        .yellow_activity      (act[3]),
        .current_screen       (current_screen),
        .winner               (winner),
        .winner_valid         (winner_valid),
        .race_timeout         (race_timeout),
        .game_over            (game_over)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit start;
        int first;
        if (!rst_n) begin
            m_screen = 0; m_winner = 4'b0; m_wv = 0; m_to = 0; m_go = 0;
            m_idle = 0; m_menu_q = 1;
            return;
        end
        start    = m_menu_q && !is_in_menu;
        m_menu_q = is_in_menu;
        m_go     = 0;
        if (reset_all) begin
            m_screen = 0; m_winner = 4'b0; m_wv = 0; m_to = 0; m_idle = 0;
        end else if (m_screen == 0) begin
            m_winner = 4'b0; m_wv = 0; m_to = 0; m_idle = 0;
            if (start) m_screen = 1;
        end else if (m_screen == 1) begin
            first = -1;
            for (int i = 3; i >= 0; i--)
                if (ready[i] && pos[i] == 4'(MAX_POS - 1)) first = i;
            if (first >= 0) begin
                m_screen = 2; m_winner = 4'b0001 << first; m_wv = 1; m_to = 0; m_go = 1;
            end else if (act != 4'b0) begin
                m_idle = 0;
            end else if (m_idle + 1 == IDLE_TO) begin
                m_screen = 2; m_winner = 4'b0; m_wv = 0; m_to = 1; m_go = 1;
            end else begin
                m_idle++;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_eq("screen",       32'(current_screen), 32'(m_screen));
        check_eq("winner",       32'(winner),         32'(m_winner));
        check_eq("winner_valid", 32'(winner_valid),   32'(m_wv));
        check_eq("race_timeout", 32'(race_timeout),   32'(m_to));
        check_eq("game_over",    32'(game_over),      32'(m_go));
    endtask

    task automatic clear_inputs();
        reset_all = 1'b0;
        ready     = 4'b1111;
        act       = 4'b0;
        for (int i = 0; i < 4; i++) pos[i] = 4'd0;
    endtask

    task automatic start_game();
        clear_inputs();
        is_in_menu = 1'b1;
        tick();
        is_in_menu = 1'b0;
        tick();
        check_eq("start_game", 32'(current_screen), 32'd1);
    endtask

    task automatic pulse_reset_all();
        reset_all = 1'b1;
        tick();
        check_eq("reset_all_menu", 32'(current_screen), 32'd0);
        reset_all = 1'b0;
        tick();
    endtask

    task automatic count_timeout(input int unsigned act_cycle, input int unsigned exp_cycles);
        int unsigned n = 0;
        start_game();
        while (m_screen == 1 && n < 100) begin
            n++;
            act = (n == act_cycle) ? 4'b0100 : 4'b0000;
            tick();
        end
        act = 4'b0;
        check_eq("timeout_cycles", n, exp_cycles);
        check_eq("timeout_flag", 32'(race_timeout), 32'd1);
        check_eq("timeout_no_win", 32'(winner_valid), 32'd0);
        pulse_reset_all();
    endtask

    task automatic random_race(input bit quiet);
        int unsigned c;
        clear_inputs();
        is_in_menu = 1'b1;
        repeat ($urandom_range(1, 3)) tick();
        is_in_menu = 1'b0;
        tick();
        c = 0;
        while (m_screen == 1 && c < 80) begin
            c++;
            ready      = 4'($urandom_range(0, 15));
            is_in_menu = 1'($urandom_range(0, 1));
            reset_all  = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < 4; i++) begin
                pos[i] = (!quiet && $urandom_range(0, 15) == 0) ? 4'd15
                                                                : 4'($urandom_range(0, 14));
                act[i] = !quiet && ($urandom_range(0, 5) == 0);
            end
            if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
            tick();
            rst_n     = 1'b1;
            reset_all = 1'b0;
        end
        repeat ($urandom_range(1, 4)) begin
            for (int i = 0; i < 4; i++) pos[i] = 4'($urandom_range(0, 15));
            act        = 4'($urandom_range(0, 15));
            is_in_menu = 1'($urandom_range(0, 1));
            tick();
        end
        clear_inputs();
        pulse_reset_all();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        rst_n      = 1'b0;
        is_in_menu = 1'b0;
        repeat (3) tick();
        check_eq("reset_screen", 32'(current_screen), 32'd0);

        is_in_menu = 1'b1;
        rst_n      = 1'b1;
        repeat (3) tick();
        check_eq("no_start_without_edge", 32'(current_screen), 32'd0);

        // Blue finishes alone.
        start_game();
        tick();
        pos[1] = 4'd15;
        tick();
        check_eq("blue_screen", 32'(current_screen), 32'd2);
        check_eq("blue_win", 32'(winner), 32'b0010);
        check_eq("blue_go_pulse", 32'(game_over), 32'd1);
        pos[1] = 4'd3;
        tick();
        check_eq("blue_go_drop", 32'(game_over), 32'd0);
        check_eq("blue_hold", 32'(winner), 32'b0010);
        pulse_reset_all();
        check_eq("after_reset_all_win", 32'(winner), 32'd0);

        // Red and green tie: red has priority.
        start_game();
        pos[0] = 4'd15;
        pos[2] = 4'd15;
        tick();
        check_eq("tie_red_win", 32'(winner), 32'b0001);
        pulse_reset_all();

        // Yellow at the finish but not registered: race continues.
        start_game();
        ready  = 4'b0111;
        pos[3] = 4'd15;
        act    = 4'b0001;
        repeat (5) tick();
        check_eq("yellow_not_ready", 32'(current_screen), 32'd1);

        // reset_all together with a finish: back to MENU, no game_over.
        pos[1]    = 4'd15;
        reset_all = 1'b1;
        tick();
        check_eq("ra_finish_screen", 32'(current_screen), 32'd0);
        check_eq("ra_finish_go", 32'(game_over), 32'd0);
        clear_inputs();
        tick();

        count_timeout(0, 20);
        count_timeout(15, 35);

        // Reset mid-GAME.
        start_game();
        act = 4'b1000;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        check_eq("mid_reset_screen", 32'(current_screen), 32'd0);
        rst_n      = 1'b1;
        is_in_menu = 1'b1;
        clear_inputs();
        tick();

        for (int r = 0; r < 40; r++) random_race(r % 4 == 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
